z3_slave_ctrl: RTL
==================

// Module: z3_slave_ctrl
// PURPOSE
//  Zorro III slave-cycle front end: synchronises FCS_n/DS_n, latches address+READ, decodes board hit.
//  Feeds ADDR/READ/FCS_n/slave_cycle to the interrupt-register and NCR access blocks.
//  Merges their acks into a registered DTACK_n; flags cycles no responder acks within a bound.
// PARAMETERS
//  SYNC_STAGES     2   flops on FCS_n and DS_n (min 2)
//  TIMEOUT_CYCLES  64  CLK cycles in WAIT_ACK before TIMEOUT (min 2)
// PORTS
//  CLK            in   1   system clock
//  RESET          in   1   asynchronous active-high reset
//  FCS_n_in       in   1   Zorro III full-cycle strobe, async
//  DS_n_in        in   4   data strobes, async
//  READ_in        in   1   bus READ, stable while FCS_n_in low
//  ADDR_in        in   32  latched bus address, stable while FCS_n_in low
//  cfg_base       in   8   board base, compared with ADDR_in[31:24]
//  configured     in   1   autoconfig done
//  int_dtack      in   1   ack from interrupt-register block
//  ext_dtack      in   1   ack from any other responder (NCR path)
//  ADDR           out  28  captured ADDR_in[27:0]
//  READ           out  1   captured READ_in
//  FCS_n          out  1   synchronised FCS_n for downstream blocks
//  slave_cycle    out  1   board-hit cycle in progress
//  DTACK_n        out  1   registered data ack to bus
//  slave_timeout  out  1   one-cycle pulse on timeout
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, ADDR=0, READ=0, FCS_n=1, slave_cycle=0,
//   DTACK_n=1, slave_timeout=0, timeout counter=0, sync chains all 1.
//  FCS_n = last stage of FCS sync chain; ds_any = any bit of synced DS_n low.
//  fcs_fall = FCS_n low && previous FCS_n high (one-cycle event).
//  States:
//   IDLE: on fcs_fall capture ADDR<=ADDR_in[27:0], READ<=READ_in.
//     If configured && ADDR_in[31:24]==cfg_base -> WAIT_DS, slave_cycle<=1; else -> MISS.
//   MISS: outputs idle; FCS_n high -> IDLE.
//   WAIT_DS: slave_cycle=1; ds_any -> WAIT_ACK, counter cleared to 0.
//   WAIT_ACK: counter++ per cycle; int_dtack||ext_dtack -> ACK, DTACK_n<=0 (same edge);
//     else counter==TIMEOUT_CYCLES-1 -> TIMEOUT, slave_timeout<=1 for that cycle only.
//   ACK: DTACK_n held 0 until FCS_n high.
//   TIMEOUT: DTACK_n stays 1 (bus error left to host); wait FCS_n high.
//  Abort: FCS_n high in any non-IDLE state -> IDLE next edge; slave_cycle<=0, DTACK_n<=1
//   on that edge. Priority over every other transition.
//  Ack and timeout in same cycle: ack wins, no timeout pulse.
//  Ack seen in WAIT_DS ignored (needs DS first).
//  Ack on the abort cycle ignored.
//  Back-to-back cycles need FCS_n high >=1 sample; no new cycle while FCS_n stays low.
//  Latency: FCS_n_in fall -> slave_cycle high = SYNC_STAGES+1 edges.
//   Ack input high -> DTACK_n low = 1 edge.
//   FCS_n_in rise -> DTACK_n high = SYNC_STAGES+1 edges.
//  ADDR/READ hold their values after cycle end until the next fcs_fall in IDLE.
//  Counter 7 bits wide minimum, saturates; never wraps within a cycle.
// TESTING
//  1 cfg_base=0x40, configured=1, ADDR_in=0x40900000, READ=1; FCS_n_in low, DS low,
//    int_dtack 2 cycles later -> slave_cycle high 3 edges after FCS fall, ADDR=0x0900000;
//    DTACK_n low 1 edge after ack; high 3 edges after FCS_n_in rise.
//  2 ADDR_in=0x41900000 -> state MISS; slave_cycle never high, DTACK_n stays 1.
//    configured=0 with base hit gives the same result.
//  3 Hit, DS low, no ack -> slave_timeout single pulse 64 cycles after WAIT_ACK entry;
//    DTACK_n stays 1; IDLE after FCS_n_in high.
//  4 ext_dtack rises on counter==63 cycle -> ACK entered, DTACK_n=0, no timeout pulse.
//  5 FCS_n_in rises during WAIT_ACK -> IDLE next edge, slave_cycle=0;
//    second cycle, READ=0, ADDR_in=0x40900004 -> ADDR=0x0900004, READ=0.
//  6 RESET pulsed while in ACK -> DTACK_n=1, slave_cycle=0 immediately (async);
//    FCS_n held low after reset release starts no cycle until a high sample.

Source files
------------

// File: rtl/z3_slave_ctrl_if.sv
// Zorro III slave-cycle bus bundle: async bus inputs, decode config,
// responder acks in; captured cycle info and the bus ack out.
interface z3_slave_ctrl_if;
  logic        FCS_n_in;
  logic [3:0]  DS_n_in;
  logic        READ_in;
  logic [31:0] ADDR_in;
  logic [7:0]  cfg_base;
  logic        configured;
  logic        int_dtack;
  logic        ext_dtack;
  logic [27:0] ADDR;
  logic        READ;
  logic        FCS_n;
  logic        slave_cycle;
  logic        DTACK_n;
  logic        slave_timeout;

  modport slave (
    input  FCS_n_in, DS_n_in, READ_in, ADDR_in, cfg_base, configured,
           int_dtack, ext_dtack,
    output ADDR, READ, FCS_n, slave_cycle, DTACK_n, slave_timeout
  );

  modport master (
    output FCS_n_in, DS_n_in, READ_in, ADDR_in, cfg_base, configured,
           int_dtack, ext_dtack,
    input  ADDR, READ, FCS_n, slave_cycle, DTACK_n, slave_timeout
  );
endinterface

// File: rtl/z3_slave_ctrl.sv
// Zorro III slave-cycle front end: synchronises FCS_n/DS_n, captures the
// address and READ, decodes a board hit, merges responder acks into a
// registered DTACK_n and flags cycles nobody acknowledges in time.
module z3_slave_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic           CLK,
  input logic           RESET,
  z3_slave_ctrl_if.slave bus
);

  localparam int CB = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int CW = (CB > 7) ? CB : 7;

  typedef enum logic [2:0] {IDLE, MISS, WAIT_DS, WAIT_ACK, ACK, TMO} state_t;

  state_t                        state, state_nxt;
  logic [SYNC_STAGES-1:0]        fcs_sync;
  logic [SYNC_STAGES-1:0]        sync_vld;
  logic [SYNC_STAGES-1:0][3:0]   ds_sync;
  logic                          fcs_prev;
  logic                          fcs_s, ds_any, fcs_fall, hit, cap;
  logic [CW-1:0]                 cnt, cnt_nxt;
  logic                          sc_q, sc_nxt, dt_q, dt_nxt, to_q, to_nxt;
  logic [27:0]                   addr_q;
  logic                          read_q;

  assign fcs_s    = fcs_sync[SYNC_STAGES-1];
  assign ds_any   = ~&ds_sync[SYNC_STAGES-1];
  assign fcs_fall = ~fcs_s & fcs_prev;
  assign hit      = bus.configured && (bus.ADDR_in[31:24] == bus.cfg_base);

  // Synchroniser chains. sync_vld marks when the chain holds real samples
  // rather than reset fill, so a strobe held low across reset release never
  // looks like a fresh falling edge: fcs_prev only arms on a genuine high.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fcs_sync <= '1;
      ds_sync  <= '1;
      sync_vld <= '0;
      fcs_prev <= 1'b0;
    end else begin
      fcs_sync <= {fcs_sync[SYNC_STAGES-2:0], bus.FCS_n_in};
      ds_sync  <= {ds_sync[SYNC_STAGES-2:0], bus.DS_n_in};
      sync_vld <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
      fcs_prev <= fcs_s & sync_vld[SYNC_STAGES-1];
    end
  end

  // Next state and next registered outputs; abort (FCS_n high) beats all.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sc_nxt    = sc_q;
    dt_nxt    = dt_q;
    to_nxt    = 1'b0;
    cap       = 1'b0;
    if (state != IDLE && fcs_s) begin
      state_nxt = IDLE;
      sc_nxt    = 1'b0;
      dt_nxt    = 1'b1;
    end else begin
      case (state)
        IDLE: if (fcs_fall) begin
          cap = 1'b1;
          if (hit) begin
            state_nxt = WAIT_DS;
            sc_nxt    = 1'b1;
          end else begin
            state_nxt = MISS;
          end
        end
        WAIT_DS: if (ds_any) begin
          state_nxt = WAIT_ACK;
          cnt_nxt   = '0;
        end
        WAIT_ACK: begin
          cnt_nxt = (cnt == '1) ? cnt : cnt + CW'(1);
          if (bus.int_dtack || bus.ext_dtack) begin
            state_nxt = ACK;
            dt_nxt    = 1'b0;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state_nxt = TMO;
            to_nxt    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State, counter, registered outputs and captured address/READ.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      cnt    <= '0;
      sc_q   <= 1'b0;
      dt_q   <= 1'b1;
      to_q   <= 1'b0;
      addr_q <= '0;
      read_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sc_q  <= sc_nxt;
      dt_q  <= dt_nxt;
      to_q  <= to_nxt;
      if (cap) begin
        addr_q <= bus.ADDR_in[27:0];
        read_q <= bus.READ_in;
      end
    end
  end

  assign bus.ADDR          = addr_q;
  assign bus.READ          = read_q;
  assign bus.FCS_n         = fcs_s;
  assign bus.slave_cycle   = sc_q;
  assign bus.DTACK_n       = dt_q;
  assign bus.slave_timeout = to_q;

endmodule
